inst_buffer: RTL and testbench

// Frontend instruction buffer between predecode and decode. Accepts up to IN_WIDTH predecoded
// 32-bit instructions per cycle (sparse slot mask), compacts them in slot order into a circular

---
 rtl/inst_buffer_pkg.sv | 21 ++
 rtl/ibuf_compact.sv | 35 +++
 rtl/inst_buffer.sv | 119 +++++++++++
 tb/tb_inst_buffer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_buffer_pkg.sv
//==============================================================================
// inst_buffer_pkg : shared sizes and entry type for the frontend inst buffer
// Revision: 1.0
//==============================================================================
`default_nettype none

package inst_buffer_pkg;

  localparam int IBUF_DEPTH     = 16;
  localparam int IBUF_WIDTH     = 8;
  localparam int IBUF_OUT_WIDTH = 4;
  localparam int FSQ_WIDTH      = 6;

  typedef struct packed {
    logic [31:0]          inst;
    logic [FSQ_WIDTH-1:0] fsqIdx;
  } IBufEntry;

endpackage

`default_nettype wire

// File: rtl/ibuf_compact.sv
//==============================================================================
// ibuf_compact : maps a sparse slot mask to dense per-slot write offsets
// Revision: 1.0
//==============================================================================
`default_nettype none

module ibuf_compact
  import inst_buffer_pkg::*;
#(
  parameter int IN_WIDTH = IBUF_WIDTH,
  localparam int OW      = $clog2(IN_WIDTH)
) (
  input  logic [IN_WIDTH-1:0]    in_en,
  input  logic                   enq,
  output logic [IN_WIDTH*OW-1:0] wr_off,
  output logic [IN_WIDTH-1:0]    wr_en
);

  logic [OW-1:0] rank;

  // Offset of a slot is the number of set bits strictly below it.
  always_comb begin
    rank   = '0;
    wr_off = '0;
    wr_en  = '0;
    for (int k = 0; k < IN_WIDTH; k++) begin
      wr_off[k*OW +: OW] = rank;
      wr_en[k]           = enq & in_en[k];
      rank               = rank + OW'(in_en[k]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_buffer.sv
//==============================================================================
// inst_buffer : circular instruction queue between predecode and decode
// Revision: 1.0
//==============================================================================
`default_nettype none

module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH     = IBUF_DEPTH,
  parameter int IN_WIDTH  = IBUF_WIDTH,
  parameter int OUT_WIDTH = IBUF_OUT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_WIDTH-1:0]           in_en,
  input  logic [$clog2(IN_WIDTH):0]     in_num,
  input  logic [IN_WIDTH*32-1:0]        in_inst,
  input  logic [FSQ_WIDTH-1:0]          in_fsqIdx,
  input  logic                          flush,
  input  logic                          out_ready,
  output logic                          ibuf_full,
  output logic [OUT_WIDTH-1:0]          out_en,
  output logic [OUT_WIDTH*32-1:0]       out_inst,
  output logic [OUT_WIDTH*FSQ_WIDTH-1:0] out_fsqIdx
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(IN_WIDTH);
  localparam logic [PW:0] FULL_LIMIT = (PW+1)'(DEPTH - IN_WIDTH);
  localparam logic [PW:0] OUT_MAX    = (PW+1)'(OUT_WIDTH);

  logic [PW:0] head_q, head_d;
  logic [PW:0] tail_q, tail_d;
  logic [PW:0] count_q, count_d;
  logic        full_q, full_d;
  IBufEntry    mem_q [DEPTH];
  IBufEntry    mem_d [DEPTH];

  logic                   enq;
  logic                   deq;
  logic [PW:0]            nin;
  logic [PW:0]            nout;
  logic [IN_WIDTH*OW-1:0] wr_off;
  logic [IN_WIDTH-1:0]    wr_en;

  assign enq = (|in_en) && !full_q && !flush;
  assign deq = out_ready && !flush;

  ibuf_compact #(
    .IN_WIDTH (IN_WIDTH)
  ) u_compact (
    .in_en  (in_en),
    .enq    (enq),
    .wr_off (wr_off),
    .wr_en  (wr_en)
  );

  always_comb begin
    nin  = enq ? (PW+1)'(in_num) : '0;
    nout = !deq ? '0 : ((count_q < OUT_MAX) ? count_q : OUT_MAX);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + nout;
      tail_d  = tail_q + nin;
      count_d = count_q + nin - nout;
    end
    // Free entries below IN_WIDTH <=> count above DEPTH-IN_WIDTH.
    full_d = count_d > FULL_LIMIT;
  end

  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < IN_WIDTH; k++) begin
      if (wr_en[k]) begin
        mem_d[tail_q[PW-1:0] + PW'(wr_off[k*OW +: OW])] =
          '{inst: in_inst[k*32 +: 32], fsqIdx: in_fsqIdx};
      end
    end
  end

  always_comb begin
    out_en     = '0;
    out_inst   = '0;
    out_fsqIdx = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      out_en[i]                           = (PW+1)'(i) < count_q;
      out_inst[i*32 +: 32]                = mem_q[head_q[PW-1:0] + PW'(i)].inst;
      out_fsqIdx[i*FSQ_WIDTH +: FSQ_WIDTH] = mem_q[head_q[PW-1:0] + PW'(i)].fsqIdx;
    end
  end

  assign ibuf_full = full_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_buffer.sv
//==============================================================================
// tb_inst_buffer : randomized + directed bench against a queue-based model
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int FW = FSQ_WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_en;
  logic [3:0]    in_num;
  logic [255:0]  in_inst;
  logic [FW-1:0] in_fsqIdx;
  logic          flush;
  logic          out_ready;
  logic          ibuf_full;
  logic [3:0]    out_en;
  logic [127:0]  out_inst;
  logic [4*FW-1:0] out_fsqIdx;

  always #5 clk = ~clk;

  inst_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .in_en      (in_en),
    .in_num     (in_num),
    .in_inst    (in_inst),
    .in_fsqIdx  (in_fsqIdx),
    .flush      (flush),
    .out_ready  (out_ready),
    .ibuf_full  (ibuf_full),
    .out_en     (out_en),
    .out_inst   (out_inst),
    .out_fsqIdx (out_fsqIdx)
  );

  typedef struct {
    logic [31:0]   inst;
    logic [FW-1:0] fsq;
  } ent_t;

  ent_t        model[$];
  logic [31:0] rx[$];
  int          n_cmp = 0;
  int          n_err = 0;

  always @(posedge clk) begin
    if (rst) assert (int'(in_num) == $countones(in_en))
      else $error("in_num does not match popcount(in_en)");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    int sz;
    logic [3:0] exp_en;
    sz = model.size();
    for (int i = 0; i < 4; i++) exp_en[i] = (i < sz);
    check($sformatf("%s_out_en", tag), 128'(out_en), 128'(exp_en));
    check($sformatf("%s_full", tag), 128'(ibuf_full), 128'(sz > 8));
    check($sformatf("%s_count", tag), 128'(dut.count_q), 128'(sz));
    check($sformatf("%s_ptrdiff", tag), 128'(5'(dut.tail_q - dut.head_q)), 128'(sz));
    for (int i = 0; i < 4 && i < sz; i++) begin
      check($sformatf("%s_inst%0d", tag, i), 128'(out_inst[i*32 +: 32]), 128'(model[i].inst));
      check($sformatf("%s_fsq%0d", tag, i), 128'(out_fsqIdx[i*FW +: FW]), 128'(model[i].fsq));
    end
  endtask

  // Inputs are held from the preceding negedge; model follows the queue rules.
  task automatic tick(input string tag);
    int nout;
    bit was_full;
    in_num = 4'($countones(in_en));
    #1;
    check_outs(tag);
    @(posedge clk);
    if (!rst || flush) begin
      model.delete();
    end else begin
      was_full = model.size() > 8;
      nout = (model.size() < 4) ? model.size() : 4;
      if (out_ready) begin
        for (int i = 0; i < nout; i++) rx.push_back(model.pop_front().inst);
      end
      if ((|in_en) && !was_full) begin
        for (int k = 0; k < 8; k++)
          if (in_en[k]) model.push_back('{inst: in_inst[k*32 +: 32], fsq: in_fsqIdx});
      end
    end
    @(negedge clk);
  endtask

  task automatic set_rand_insts();
    for (int k = 0; k < 8; k++) in_inst[k*32 +: 32] = $urandom;
    in_fsqIdx = FW'($urandom);
  endtask

  initial begin
    int seq;
    int guard;
    int marked;

    rst = 1'b0; in_en = 8'hFF; in_num = 4'd8; in_inst = '0;
    in_fsqIdx = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset with a full input mask
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; in_en = 8'h00;
    #1;
    check("reset_out_en", 128'(out_en), 128'(4'b0000));
    check("reset_full", 128'(ibuf_full), 128'(1'b0));
    check("reset_count", 128'(dut.count_q), 128'(0));
    tick("reset");

    // Sparse compaction
    in_en = 8'b1010_0110;
    in_inst = '0;
    in_inst[1*32 +: 32] = 32'hAAAA_0001;
    in_inst[2*32 +: 32] = 32'hBBBB_0002;
    in_inst[5*32 +: 32] = 32'hCCCC_0005;
    in_inst[7*32 +: 32] = 32'hDDDD_0007;
    in_fsqIdx = 6'd5;
    tick("sparse_wr");
    in_en = 8'h00;
    #1;
    check("sparse_out_en", 128'(out_en), 128'(4'b1111));
    check("sparse_out_inst", 128'(out_inst),
          {32'hDDDD_0007, 32'hCCCC_0005, 32'hBBBB_0002, 32'hAAAA_0001});
    out_ready = 1'b1;
    tick("sparse_drain");
    out_ready = 1'b0;

    // Full threshold and ignored enqueue while full
    in_en = 8'hFF; set_rand_insts(); tick("full_a");
    in_en = 8'h0F; set_rand_insts(); tick("full_b");
    #1;
    check("full_count12", 128'(dut.count_q), 128'(12));
    check("full_flag", 128'(ibuf_full), 128'(1'b1));
    in_en = 8'hFF; set_rand_insts(); tick("full_ignored");
    #1;
    check("full_ignored_count", 128'(dut.count_q), 128'(12));
    in_en = 8'h00; out_ready = 1'b1; tick("full_deq");
    out_ready = 1'b0;
    #1;
    check("full_after_deq_count", 128'(dut.count_q), 128'(8));
    check("full_after_deq_flag", 128'(ibuf_full), 128'(1'b0));
    out_ready = 1'b1;
    tick("full_drain1");
    tick("full_drain2");

    // Partial dequeue group
    out_ready = 1'b0; in_en = 8'b0000_0111; set_rand_insts(); tick("part_wr");
    in_en = 8'h00; out_ready = 1'b1;
    #1;
    check("part_out_en", 128'(out_en), 128'(4'b0111));
    tick("part_deq");
    #1;
    check("part_count0", 128'(dut.count_q), 128'(0));
    check("part_out_en0", 128'(out_en), 128'(4'b0000));

    // Sequential stream across the wrap boundary
    rx.delete();
    seq = 0; guard = 0;
    while ((rx.size() < 40 || model.size() != 0) && guard < 200) begin
      if (seq < 40 && model.size() <= 8) begin
        in_en = 8'hFF;
        for (int k = 0; k < 8; k++) in_inst[k*32 +: 32] = 32'(seq + k);
        seq += 8;
      end else begin
        in_en = 8'h00;
      end
      out_ready = guard[0];
      tick("wrap");
      guard++;
    end
    check("wrap_rx_count", 128'(rx.size()), 128'(40));
    for (int i = 0; i < rx.size() && i < 40; i++)
      check($sformatf("wrap_rx%0d", i), 128'(rx[i]), 128'(i));

    // Flush colliding with enqueue and dequeue
    out_ready = 1'b0; in_en = 8'hFF; set_rand_insts(); tick("fl_a");
    in_en = 8'h03; set_rand_insts(); tick("fl_b");
    #1;
    check("fl_count10", 128'(dut.count_q), 128'(10));
    flush = 1'b1; out_ready = 1'b1; in_en = 8'hFF;
    for (int k = 0; k < 8; k++) in_inst[k*32 +: 32] = 32'hDEAD_0000 | 32'(k);
    tick("fl_hit");
    flush = 1'b0; in_en = 8'h00;
    #1;
    check("fl_count0", 128'(dut.count_q), 128'(0));
    check("fl_out_en0", 128'(out_en), 128'(4'b0000));
    check("fl_full0", 128'(ibuf_full), 128'(1'b0));
    rx.delete();
    out_ready = 1'b1;
    in_en = 8'h3C; set_rand_insts(); tick("fl_post_wr");
    in_en = 8'h00;
    repeat (3) tick("fl_post_drain");
    marked = 0;
    foreach (rx[i]) if (rx[i][31:16] == 16'hDEAD) marked++;
    check("fl_no_stale", 128'(marked), 128'(0));

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      in_en = ($urandom_range(0, 9) < 3) ? 8'h00 : 8'($urandom);
      set_rand_insts();
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 24) == 0;
      tick("rand");
    end
    flush = 1'b0; in_en = 8'h00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
